load_unit_ctrl: RTL and testbench

//  Sequences RV32I loads (LB/LH/LW/LBU/LHU) between the execute stage and data memory.
//  - Accepts one load request and issues word-aligned memory reads.
//  - Selects the addressed byte, halfword or word and zero/sign-extends it to 32 bits.
//  - Returns the result with the destination register index.
//  - Sits between the execute stage and the data-memory port; feeds the writeback mux.

---
 rtl/load_unit_ctrl_pkg.sv | 31 +++
 rtl/load_unit_ctrl_extend.sv | 35 +++
 rtl/load_unit_ctrl.sv | 147 ++++++++++++++
 tb/tb_load_unit_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_ctrl_pkg.sv
// Shared definitions for the RV32I load sequencer: funct3 encodings,
// FSM state type and small decode helpers.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  // True for the five load encodings this unit implements.
  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // True when the access spills past the end of its aligned word.
  // A halfword at offset 1 still fits in the word.
  function automatic logic is_cross(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == F3_LH) || (f3 == F3_LHU)) && (off == 2'd3)) ||
           ((f3 == F3_LW) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/load_unit_ctrl_extend.sv
// load_extend: combinational byte/halfword/word select and extension.
// {hi,lo} is the little-endian pair of words covering the access; off is
// the byte offset of the access inside lo.
module load_extend
  import load_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] pair;
  logic [XLEN-1:0]   sh;

  assign pair = {hi, lo};

  // Shift the addressed bytes down to bit 0, then extend by load type.
  always_comb begin
    sh     = pair[{off, 3'b000} +: XLEN];
    result = '0;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){sh[7]}}, sh[7:0]};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_LH:   result = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, sh[15:0]};
      F3_LW:   result = sh;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_unit_ctrl.sv
// load_unit_ctrl: sequences one RV32I load at a time from execute to data
// memory and returns the extended result with its destination register.
// Build option MISALIGN_SPLIT_EN: when defined, word-crossing loads are
// served with two aligned reads; otherwise they fault without a memory read.
module load_unit_ctrl
  import load_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_fault
);

  state_t            state_reg, state_next;
  logic [ADDR_W-3:0] word_reg;
  logic [1:0]        off_reg;
  logic [2:0]        funct3_reg;
  logic              accept;
  logic              req_bad;
  logic [XLEN-1:0]   ext_hi, ext_lo, ext_result;

  assign accept = req_valid && (state_reg == IDLE);

`ifdef MISALIGN_SPLIT_EN
  localparam logic [ADDR_W-3:0] WORD_ONE = 1;
  logic [XLEN-1:0] lo_reg;
  logic            cur_cross;

  assign cur_cross = is_cross(funct3_reg, off_reg);
  assign req_bad   = !f3_legal(req_funct3);
  // First word comes live from memory in ACC0, from lo_reg in ACC1.
  assign ext_lo    = (state_reg == ACC0) ? mem_rdata : lo_reg;
  assign ext_hi    = (state_reg == ACC1) ? mem_rdata : '0;
`else
  assign req_bad   = !f3_legal(req_funct3) || is_cross(req_funct3, req_addr[1:0]);
  assign ext_lo    = mem_rdata;
  assign ext_hi    = '0;
`endif

  load_extend #(.XLEN(XLEN)) u_extend (
    .hi     (ext_hi),
    .lo     (ext_lo),
    .off    (off_reg),
    .funct3 (funct3_reg),
    .result (ext_result)
  );

  // State register; async reset drops mem_req immediately via the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_bad ? RESP : ACC0;
      end
      ACC0: begin
        mem_req = 1'b1;
        if (mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
          state_next = cur_cross ? ACC1 : RESP;
`else
          state_next = RESP;
`endif
        end
      end
`ifdef MISALIGN_SPLIT_EN
      ACC1: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = RESP;
      end
`endif
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read address: aligned base in ACC0, next word (wrapping) in ACC1.
  always_comb begin
    mem_addr = {word_reg, 2'b00};
`ifdef MISALIGN_SPLIT_EN
    if (state_reg == ACC1) mem_addr = {word_reg + WORD_ONE, 2'b00};
`endif
  end

  assign resp_valid = (state_reg == RESP);

  // Capture request fields and build the response as data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_reg   <= '0;
      off_reg    <= '0;
      funct3_reg <= '0;
      resp_rd    <= '0;
      resp_data  <= '0;
      resp_fault <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      lo_reg     <= '0;
`endif
    end else begin
      if (accept) begin
        word_reg   <= req_addr[ADDR_W-1:2];
        off_reg    <= req_addr[1:0];
        funct3_reg <= req_funct3;
        resp_rd    <= req_rd;
        resp_fault <= req_bad;
        if (req_bad) resp_data <= '0;
      end
      if ((state_reg == ACC0) && mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
        lo_reg <= mem_rdata;
        if (!cur_cross) resp_data <= ext_result;
`else
        resp_data <= ext_result;
`endif
      end
`ifdef MISALIGN_SPLIT_EN
      if ((state_reg == ACC1) && mem_ack) resp_data <= ext_result;
`endif
    end
  end

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Self-checking bench for load_unit_ctrl. Follows MISALIGN_SPLIT_EN in the
// same way as the design.
module tb_load_unit_ctrl;

`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_fault;

  int checks = 0;
  int failures = 0;

  int          ack_delay = 0;
  int          wait_cnt;
  bit          in_access;
  bit          force_ack = 1'b0;
  logic [31:0] held_addr;
  int          req_cycles;
  logic [31:0] addr_q[$];
  logic [31:0] mem_init[logic [31:0]];

  load_unit_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_fault(resp_fault)
  );

  always #5 clk = ~clk;

  // Memory image: explicit words where set, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_init.exists(w)) return mem_init[w];
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Reference: gather the bytes a load touches, little-endian, then extend.
  function automatic void model(input logic [31:0] addr, input logic [2:0] f3,
                                output logic [31:0] data, output logic flt,
                                output int nacc, output logic [31:0] a0,
                                output logic [31:0] a1);
    int width;
    logic [31:0] a, b;
    case (f3)
      3'd0, 3'd4: width = 1;
      3'd1, 3'd5: width = 2;
      3'd2:       width = 4;
      default:    width = 0;
    endcase
    a0 = addr & 32'hFFFF_FFFC;
    a1 = a0 + 32'd4;
    data = 32'd0;
    flt = 1'b0;
    nacc = ((addr % 4) + width > 4) ? 2 : 1;
    if (width == 0 || (nacc == 2 && !SPLIT)) begin
      flt = 1'b1;
      nacc = 0;
      return;
    end
    for (int i = 0; i < width; i++) begin
      a = addr + i;
      b = (mem_word(a) >> (8 * (a % 4))) & 32'hFF;
      data = data | (b << (8 * i));
    end
    if (f3 == 3'd0 && data[7])  data = data | 32'hFFFF_FF00;
    if (f3 == 3'd1 && data[15]) data = data | 32'hFFFF_0000;
  endfunction

  // Memory responder: acks after ack_delay waiting cycles, checks address stability.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    wait_cnt = 0;
    in_access = 1'b0;
    req_cycles = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (force_ack) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end else if (mem_req) begin
        req_cycles++;
        if (in_access) begin
          checks++;
          if (mem_addr !== held_addr) begin
            failures++;
            $display("FAIL mem_addr_stable got=%h want=%h", mem_addr, held_addr);
          end
        end else begin
          in_access = 1'b1;
          held_addr = mem_addr;
        end
        if (wait_cnt >= ack_delay) begin
          checks++;
          if (mem_addr[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL mem_addr_aligned got=%h want=xxxxxxx0/4/8/c", mem_addr);
          end
          mem_ack = 1'b1;
          mem_rdata = mem_word(mem_addr);
          addr_q.push_back(mem_addr);
          wait_cnt = 0;
          in_access = 1'b0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        in_access = 1'b0;
      end
    end
  end

  // Drive one load through accept, response hold and release; return observations.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                         input int delay, input int hold,
                         output logic [31:0] d, output logic flt, output logic [4:0] r,
                         output int lat, output bit changed, output bit busy_ready,
                         output logic ready_after, output logic valid_after);
    ack_delay = delay;
    addr_q.delete();
    req_cycles = 0;
    @(negedge clk);
    req_addr = addr;
    req_funct3 = f3;
    req_rd = rd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom;
    req_funct3 = 3'($urandom);
    req_rd = 5'($urandom);
    lat = 1;
    busy_ready = 1'b0;
    while (resp_valid !== 1'b1 && lat < 100) begin
      if (req_ready !== 1'b0) busy_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    d = resp_data;
    flt = resp_fault;
    r = resp_rd;
    changed = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== d || resp_fault !== flt ||
          resp_rd !== r || req_ready !== 1'b0) changed = 1'b1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    ready_after = req_ready;
    valid_after = resp_valid;
    $display("load addr=%h f3=%0d rd=%0d -> data=%h fault=%0b rd=%0d lat=%0d",
             addr, f3, rd, d, flt, r, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = 32'd0;
    req_funct3 = 3'd0;
    req_rd = 5'd0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, mem_req, resp_valid, resp_fault} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=1000", {req_ready, mem_req, resp_valid, resp_fault});
    end
    checks++;
    if (mem_addr !== 32'd0 || resp_data !== 32'd0 || resp_rd !== 5'd0) begin
      failures++;
      $display("FAIL reset_values got addr=%h data=%h rd=%0d want 0/0/0", mem_addr, resp_data, resp_rd);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] addrs[4] = '{32'h103, 32'h103, 32'h102, 32'h100};
    logic [2:0]  f3s[4]   = '{3'd0, 3'd4, 3'd5, 3'd2};
    logic [31:0] want[4]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80AA, 32'h80AA_BBCC};
    logic [31:0] d;
    logic flt, ra, va;
    logic [4:0] r;
    int lat;
    bit ch, br;
    mem_init[32'h100] = 32'h80AA_BBCC;
    for (int i = 0; i < 4; i++) begin
      do_load(addrs[i], f3s[i], 5'(i + 3), 0, 0, d, flt, r, lat, ch, br, ra, va);
      checks++;
      if (d !== want[i] || flt !== 1'b0) begin
        failures++;
        $display("FAIL directed_data[%0d] got=%h fault=%0b want=%h fault=0", i, d, flt, want[i]);
      end
      checks++;
      if (lat !== 2 || r !== 5'(i + 3)) begin
        failures++;
        $display("FAIL directed_lat_rd[%0d] got lat=%0d rd=%0d want lat=2 rd=%0d", i, lat, r, i + 3);
      end
    end
  endtask

  task automatic test_split();
    logic [31:0] d;
    logic flt, ra, va;
    logic [4:0] r;
    int lat;
    bit ch, br;
    mem_init[32'h1FC] = 32'h1122_3344;
    mem_init[32'h200] = 32'h5566_7788;
    do_load(32'h1FE, 3'd2, 5'd9, 0, 0, d, flt, r, lat, ch, br, ra, va);
    if (SPLIT) begin
      checks++;
      if (d !== 32'h7788_1122 || flt !== 1'b0 || lat !== 3) begin
        failures++;
        $display("FAIL split_lw got data=%h fault=%0b lat=%0d want data=77881122 fault=0 lat=3", d, flt, lat);
      end
      checks++;
      if (addr_q.size() !== 2 || addr_q[0] !== 32'h1FC || addr_q[1] !== 32'h200) begin
        failures++;
        $display("FAIL split_addrs got n=%0d want 1fc,200", addr_q.size());
      end
    end else begin
      checks++;
      if (d !== 32'd0 || flt !== 1'b1 || req_cycles !== 0 || lat !== 1) begin
        failures++;
        $display("FAIL nosplit_fault got data=%h fault=%0b memcycles=%0d lat=%0d want 0/1/0/1",
                 d, flt, req_cycles, lat);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    logic flt, ra, va;
    logic [4:0] r;
    int lat;
    bit ch, br;
    do_load(32'h100, 3'b011, 5'd17, 0, 3, d, flt, r, lat, ch, br, ra, va);
    checks++;
    if (flt !== 1'b1 || d !== 32'd0 || r !== 5'd17 || req_cycles !== 0) begin
      failures++;
      $display("FAIL illegal_f3 got fault=%0b data=%h rd=%0d memcycles=%0d want 1/0/17/0", flt, d, r, req_cycles);
    end
    checks++;
    if (ch !== 1'b0) begin
      failures++;
      $display("FAIL illegal_hold_stable got changed=%0b want 0", ch);
    end
    checks++;
    if (ra !== 1'b1 || va !== 1'b0) begin
      failures++;
      $display("FAIL illegal_release got ready=%0b valid=%0b want 1/0", ra, va);
    end
  endtask

  task automatic test_ack_delay();
    logic [31:0] d;
    logic flt, ra, va;
    logic [4:0] r;
    int lat;
    bit ch, br;
    do_load(32'h100, 3'd2, 5'd4, 4, 1, d, flt, r, lat, ch, br, ra, va);
    checks++;
    if (d !== 32'h80AA_BBCC || lat !== 6 || req_cycles !== 5) begin
      failures++;
      $display("FAIL ack_delay got data=%h lat=%0d memcycles=%0d want 80aabbcc/6/5", d, lat, req_cycles);
    end
    checks++;
    if (br !== 1'b0) begin
      failures++;
      $display("FAIL busy_ready got=%0b want 0", br);
    end
  endtask

  task automatic test_reset_mid();
    ack_delay = 10;
    @(negedge clk);
    req_addr = 32'h100;
    req_funct3 = 3'd2;
    req_rd = 5'd6;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_mem_req got=%0b want 1", mem_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got mem_req=%0b ready=%0b valid=%0b want 0/1/0", mem_req, req_ready, resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #2 force_ack = 1'b1;
    @(negedge clk);
    #2 force_ack = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL late_ack_ignored got valid=%0b mem_req=%0b ready=%0b want 0/0/1", resp_valid, mem_req, req_ready);
    end
    ack_delay = 0;
  endtask

  task automatic test_wrap();
    logic [31:0] d, md, a0, a1;
    logic flt, mf, ra, va;
    logic [4:0] r;
    int lat, n;
    bit ch, br;
    model(32'hFFFF_FFFE, 3'd2, md, mf, n, a0, a1);
    do_load(32'hFFFF_FFFE, 3'd2, 5'd1, 0, 0, d, flt, r, lat, ch, br, ra, va);
    checks++;
    if (d !== md || flt !== mf) begin
      failures++;
      $display("FAIL wrap_data got=%h/%0b want=%h/%0b", d, flt, md, mf);
    end
    checks++;
    if (addr_q.size() !== n || (n == 2 && (addr_q[0] !== 32'hFFFF_FFFC || addr_q[1] !== 32'h0))) begin
      failures++;
      $display("FAIL wrap_addrs got n=%0d want n=%0d fffffffc,00000000", addr_q.size(), n);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, d, md, a0, a1;
    logic [2:0] f3;
    logic [4:0] rd, r;
    logic flt, mf, ra, va;
    int lat, n, dly, hold;
    bit ch, br;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else addr = 32'h1000 + $urandom_range(0, 255);
      f3 = 3'($urandom_range(0, 7));
      rd = 5'($urandom);
      dly = $urandom_range(0, 3);
      hold = $urandom_range(0, 2);
      model(addr, f3, md, mf, n, a0, a1);
      do_load(addr, f3, rd, dly, hold, d, flt, r, lat, ch, br, ra, va);
      checks++;
      if (d !== md || flt !== mf || r !== rd) begin
        failures++;
        $display("FAIL rand_result[%0d] got data=%h fault=%0b rd=%0d want data=%h fault=%0b rd=%0d",
                 t, d, flt, r, md, mf, rd);
      end
      checks++;
      if (lat !== 1 + n * (dly + 1) || req_cycles !== n * (dly + 1)) begin
        failures++;
        $display("FAIL rand_timing[%0d] got lat=%0d memcycles=%0d want lat=%0d memcycles=%0d",
                 t, lat, req_cycles, 1 + n * (dly + 1), n * (dly + 1));
      end
      checks++;
      if (addr_q.size() !== n || (n >= 1 && addr_q[0] !== a0) || (n == 2 && addr_q[1] !== a1)) begin
        failures++;
        $display("FAIL rand_addrs[%0d] got n=%0d want n=%0d base=%h", t, addr_q.size(), n, a0);
      end
      checks++;
      if (ch !== 1'b0 || br !== 1'b0 || ra !== 1'b1 || va !== 1'b0) begin
        failures++;
        $display("FAIL rand_handshake[%0d] got changed=%0b busy_ready=%0b ready=%0b valid=%0b want 0/0/1/0",
                 t, ch, br, ra, va);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_split();
    test_illegal();
    test_ack_delay();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
